// File: rtl/alu_pkg.sv
// Shared types for the execute-stage sequencer: micro-op and condition encodings,
// flag bit positions, FSM states and the latched-op payload.
package alu_pkg;

  localparam int unsigned UOP_W  = 5;
  localparam int unsigned DATA_W = 32;

  // Bit positions inside a [0:3] flags vector {Z,C,N,V}
  localparam int unsigned FLAG_Z = 0;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_N = 2;
  localparam int unsigned FLAG_V = 3;

  typedef enum logic [UOP_W-1:0] {
    NOP = 5'b00000,
    ADD = 5'b00001,
    SUB = 5'b00010,
    AND = 5'b00011,
    ORR = 5'b00100,
    CMP = 5'b00101,
    EOR = 5'b00110,
    MOV = 5'b00111,
    MVN = 5'b01000,
    STR = 5'b01001,
    LDR = 5'b01010
  } uop_e;

  typedef enum logic [3:0] {
    EQ, NE, CS, CC, MI, PL, VS, VC, HI, LS, GE, LT, GT, LE, AL, NV
  } cond_e;

  typedef enum logic [1:0] {IDLE, EXEC, WB, MEM} state_e;

  // Decoded op captured at the input handshake
  typedef struct packed {
    logic [UOP_W-1:0]  uop;
    logic [3:0]        cond;
    logic              set_flags;
    logic [DATA_W-1:0] lhs;
    logic [DATA_W-1:0] rhs;
    logic [DATA_W-1:0] str_data;
  } op_t;

endpackage

// File: rtl/cond_eval.sv
// ARM condition-code evaluator (combinational).
//   cond  : 4-bit condition field
//   flags : architectural {Z,C,N,V}, index 0 = Z
//   pass  : 1 when the op should execute
module cond_eval (
  input  logic [3:0] cond,
  input  logic [0:3] flags,
  output logic       pass
);
  import alu_pkg::*;

  logic z, c, n, v;

  always_comb begin
    z    = flags[FLAG_Z];
    c    = flags[FLAG_C];
    n    = flags[FLAG_N];
    v    = flags[FLAG_V];
    pass = 1'b1;
    case (cond_e'(cond))
      EQ:      pass = z;
      NE:      pass = !z;
      CS:      pass = c;
      CC:      pass = !c;
      MI:      pass = n;
      PL:      pass = !n;
      VS:      pass = v;
      VC:      pass = !v;
      HI:      pass = c && !z;
      LS:      pass = !c || z;
      GE:      pass = (n == v);
      LT:      pass = (n != v);
      GT:      pass = !z && (n == v);
      LE:      pass = z || (n != v);
      default: pass = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_exec_ctrl.sv
// Execute-stage sequencer: accepts one decoded op per handshake, drives the external
// ALU for one cycle, owns the NZCV flags register and routes results to writeback or
// the data-memory port.
// Ports: clk/rst (sync active-high); in_* op handshake; alu_* to/from ALU;
//        wb_* writeback handshake; mem_* memory request/ack; flags; mem_err pulse.
// Config macro: EXEC_COND_EN -- when defined, in_cond gates execution via cond_eval;
//               otherwise every op executes.
module alu_exec_ctrl #(
  parameter int unsigned REG_ADDR_W  = 4,
  parameter int unsigned MEM_TIMEOUT = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [4:0]            in_uop,
  input  logic [3:0]            in_cond,
  input  logic                  in_set_flags,
  input  logic [31:0]           in_lhs,
  input  logic [31:0]           in_rhs,
  input  logic [REG_ADDR_W-1:0] in_rd,
  input  logic [31:0]           in_str_data,
  output logic [4:0]            alu_uop,
  output logic [31:0]           alu_lhs,
  output logic [31:0]           alu_rhs,
  input  logic [31:0]           alu_out,
  input  logic [0:3]            alu_flags,
  output logic                  wb_valid,
  input  logic                  wb_ready,
  output logic [REG_ADDR_W-1:0] wb_rd,
  output logic [31:0]           wb_data,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [31:0]           mem_addr,
  output logic [31:0]           mem_wdata,
  input  logic                  mem_ack,
  input  logic [31:0]           mem_rdata,
  output logic [0:3]            flags,
  output logic                  mem_err
);
  import alu_pkg::*;

  localparam int unsigned TMO_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

  state_e                state, state_nxt;
  op_t                   op, op_nxt;
  logic [REG_ADDR_W-1:0] rd, rd_nxt;
  logic [0:3]            flags_nxt;
  logic                  wb_valid_nxt, mem_req_nxt, mem_we_nxt, mem_err_nxt;
  logic [REG_ADDR_W-1:0] wb_rd_nxt;
  logic [31:0]           wb_data_nxt, mem_addr_nxt, mem_wdata_nxt;
  logic [TMO_W-1:0]      tmo_cnt, tmo_cnt_nxt;
  logic                  cond_pass;

`ifdef EXEC_COND_EN
  cond_eval u_cond_eval (
    .cond  (op.cond),
    .flags (flags),
    .pass  (cond_pass)
  );
`else
  logic cond_unused;
  assign cond_pass   = 1'b1;
  assign cond_unused = ^op.cond;
`endif

  assign in_ready = (state == IDLE) && !rst;
  assign alu_lhs  = op.lhs;
  assign alu_rhs  = op.rhs;

  // Next-state, ALU drive and next values for all registered outputs
  always_comb begin
    state_nxt     = state;
    op_nxt        = op;
    rd_nxt        = rd;
    flags_nxt     = flags;
    wb_valid_nxt  = wb_valid;
    wb_rd_nxt     = wb_rd;
    wb_data_nxt   = wb_data;
    mem_req_nxt   = mem_req;
    mem_we_nxt    = mem_we;
    mem_addr_nxt  = mem_addr;
    mem_wdata_nxt = mem_wdata;
    mem_err_nxt   = 1'b0;
    tmo_cnt_nxt   = tmo_cnt;
    alu_uop       = NOP;

    case (state)
      IDLE: begin
        if (in_valid) begin
          op_nxt.uop       = in_uop;
          op_nxt.cond      = in_cond;
          op_nxt.set_flags = in_set_flags;
          op_nxt.lhs       = in_lhs;
          op_nxt.rhs       = in_rhs;
          op_nxt.str_data  = in_str_data;
          rd_nxt           = in_rd;
          state_nxt        = EXEC;
        end
      end

      EXEC: begin
        alu_uop = op.uop;
        if (!cond_pass) begin
          state_nxt = IDLE;
        end else begin
          case (op.uop)
            LDR, STR: begin
              mem_req_nxt   = 1'b1;
              mem_we_nxt    = (op.uop == STR);
              mem_addr_nxt  = alu_out;
              mem_wdata_nxt = op.str_data;
              tmo_cnt_nxt   = '0;
              state_nxt     = MEM;
            end
            CMP: begin
              flags_nxt = alu_flags;
              state_nxt = IDLE;
            end
            ADD, SUB, AND, ORR, EOR, MOV, MVN: begin
              wb_valid_nxt = 1'b1;
              wb_rd_nxt    = rd;
              wb_data_nxt  = alu_out;
              if (op.set_flags) flags_nxt = alu_flags;
              state_nxt    = WB;
            end
            default: state_nxt = IDLE;
          endcase
        end
      end

      WB: begin
        if (wb_ready) begin
          wb_valid_nxt = 1'b0;
          state_nxt    = IDLE;
        end
      end

      MEM: begin
        // An ack always beats a simultaneous timeout
        if (mem_ack) begin
          mem_req_nxt = 1'b0;
          if (mem_we) begin
            state_nxt = IDLE;
          end else begin
            wb_valid_nxt = 1'b1;
            wb_rd_nxt    = rd;
            wb_data_nxt  = mem_rdata;
            state_nxt    = WB;
          end
        end else if ((MEM_TIMEOUT != 0) && (tmo_cnt == TMO_W'(MEM_TIMEOUT - 1))) begin
          mem_req_nxt = 1'b0;
          mem_err_nxt = 1'b1;
          state_nxt   = IDLE;
        end else begin
          tmo_cnt_nxt = tmo_cnt + TMO_W'(1);
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

  // State and output registers; reset aborts any op in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      op        <= '0;
      rd        <= '0;
      flags     <= '0;
      wb_valid  <= 1'b0;
      wb_rd     <= '0;
      wb_data   <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_err   <= 1'b0;
      tmo_cnt   <= '0;
    end else begin
      state     <= state_nxt;
      op        <= op_nxt;
      rd        <= rd_nxt;
      flags     <= flags_nxt;
      wb_valid  <= wb_valid_nxt;
      wb_rd     <= wb_rd_nxt;
      wb_data   <= wb_data_nxt;
      mem_req   <= mem_req_nxt;
      mem_we    <= mem_we_nxt;
      mem_addr  <= mem_addr_nxt;
      mem_wdata <= mem_wdata_nxt;
      mem_err   <= mem_err_nxt;
      tmo_cnt   <= tmo_cnt_nxt;
    end
  end

endmodule

// File: tb/tb_alu_exec_ctrl.sv
// Scoreboard bench for alu_exec_ctrl: directed ops push expected writeback / memory
// transactions into queues; a negedge monitor pops and compares on each handshake.
module tb_alu_exec_ctrl;
  import alu_pkg::*;

  logic        clk, rst;
  logic        in_valid, in_ready, in_set_flags;
  logic [4:0]  in_uop, alu_uop;
  logic [3:0]  in_cond, in_rd, wb_rd;
  logic [31:0] in_lhs, in_rhs, in_str_data;
  logic [31:0] alu_lhs, alu_rhs, alu_out;
  logic [0:3]  alu_flags, flags;
  logic        wb_valid, wb_ready;
  logic [31:0] wb_data;
  logic        mem_req, mem_we, mem_ack, mem_err;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  alu_exec_ctrl #(.REG_ADDR_W(4), .MEM_TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_uop(in_uop), .in_cond(in_cond),
    .in_set_flags(in_set_flags), .in_lhs(in_lhs), .in_rhs(in_rhs), .in_rd(in_rd),
    .in_str_data(in_str_data),
    .alu_uop(alu_uop), .alu_lhs(alu_lhs), .alu_rhs(alu_rhs), .alu_out(alu_out),
    .alu_flags(alu_flags),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd(wb_rd), .wb_data(wb_data),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .flags(flags), .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  // Reference ALU (ARM semantics: C = carry out / no borrow)
  logic [32:0] t;
  always_comb begin
    t         = '0;
    alu_out   = '0;
    alu_flags = '0;
    case (alu_uop)
      ADD:      t = {1'b0, alu_lhs} + {1'b0, alu_rhs};
      SUB, CMP: t = {1'b0, alu_lhs} + {1'b0, ~alu_rhs} + 33'd1;
      AND:      t = {1'b0, alu_lhs & alu_rhs};
      ORR:      t = {1'b0, alu_lhs | alu_rhs};
      EOR:      t = {1'b0, alu_lhs ^ alu_rhs};
      MOV:      t = {1'b0, alu_rhs};
      MVN:      t = {1'b0, ~alu_rhs};
      LDR, STR: t = {1'b0, alu_lhs + alu_rhs};
      default:  t = '0;
    endcase
    alu_out          = t[31:0];
    alu_flags[FLAG_Z] = (t[31:0] == 32'd0);
    alu_flags[FLAG_C] = t[32];
    alu_flags[FLAG_N] = t[31];
    if (alu_uop == ADD)
      alu_flags[FLAG_V] = (alu_lhs[31] == alu_rhs[31]) && (t[31] != alu_lhs[31]);
    else if (alu_uop == SUB || alu_uop == CMP)
      alu_flags[FLAG_V] = (alu_lhs[31] != alu_rhs[31]) && (t[31] != alu_lhs[31]);
  end

  typedef struct packed { logic [3:0] rd; logic [31:0] data; } wb_exp_t;
  typedef struct packed { logic we; logic [31:0] addr; logic [31:0] wdata; } mem_exp_t;

  wb_exp_t  wb_q[$];
  mem_exp_t mem_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  int err_seen = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: compare every writeback / memory handshake against the queues
  always @(negedge clk) begin
    wb_exp_t  we;
    mem_exp_t me;
    if (!rst && wb_valid && wb_ready) begin
      if (wb_q.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL wb_unexpected: rd %h data %h with no expected writeback", wb_rd, wb_data);
      end else begin
        we = wb_q.pop_front();
        check("wb_rd", 32'(wb_rd), 32'(we.rd));
        check("wb_data", wb_data, we.data);
      end
    end
    if (!rst && mem_req && mem_ack) begin
      if (mem_q.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL mem_unexpected: addr %h we %b with no expected access", mem_addr, mem_we);
      end else begin
        me = mem_q.pop_front();
        check("mem_we", 32'(mem_we), 32'(me.we));
        check("mem_addr", mem_addr, me.addr);
        check("mem_wdata", mem_wdata, me.wdata);
      end
    end
    if (mem_err === 1'b1) err_seen++;
  end

  task automatic wait_ready();
    int n = 0;
    while (!in_ready && n < 30) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) begin
      n_checks++; n_fail++;
      $display("FAIL in_ready_timeout: got %b expected 1", in_ready);
    end
  endtask

  // Present one op and return 1 time unit after the accept edge (state = EXEC)
  task automatic issue(input logic [4:0] uop, input logic [3:0] cond, input logic s,
                       input logic [31:0] lhs, input logic [31:0] rhs,
                       input logic [3:0] rd, input logic [31:0] sd);
    wait_ready();
    in_valid = 1'b1; in_uop = uop; in_cond = cond; in_set_flags = s;
    in_lhs = lhs; in_rhs = rhs; in_rd = rd; in_str_data = sd;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [3:0] tc [13];
  logic       tp [13];

  initial begin
    int req_cnt, err0;
    logic exp_pass;
    clk = 1'b0; rst = 1'b1; in_valid = 1'b0; in_uop = '0; in_cond = '0;
    in_set_flags = 1'b0; in_lhs = '0; in_rhs = '0; in_rd = '0; in_str_data = '0;
    wb_ready = 1'b1; mem_ack = 1'b0; mem_rdata = '0;

    // Reset state
    @(negedge clk);
    check("rst_in_ready_low", 32'(in_ready), 32'd0);
    @(posedge clk); @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_flags", 32'(flags), 32'd0);
    check("rst_wb_valid", 32'(wb_valid), 32'd0);
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_mem_err", 32'(mem_err), 32'd0);
    check("rst_wb_data", wb_data, 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("idle_alu_uop", 32'(alu_uop), 32'(NOP));

    // ADD 5+7, S=1: result 12, flags 0000, wb_valid on the second cycle after accept
    wb_q.push_back('{rd: 4'd3, data: 32'd12});
    issue(ADD, AL, 1'b1, 32'd5, 32'd7, 4'd3, 32'd0);
    @(negedge clk);
    check("add_exec_wb_valid", 32'(wb_valid), 32'd0);
    check("add_alu_uop", 32'(alu_uop), 32'(ADD));
    check("add_alu_lhs", alu_lhs, 32'd5);
    check("add_alu_rhs", alu_rhs, 32'd7);
    @(negedge clk);
    check("add_latency_wb_valid", 32'(wb_valid), 32'd1);
    @(negedge clk);
    check("add_flags", 32'(flags), 32'h0);
    check("add_back_idle", 32'(in_ready), 32'd1);

    // CMP 3,3: Z=1 C=1, no writeback
    issue(CMP, AL, 1'b0, 32'd3, 32'd3, 4'd1, 32'd0);
    @(negedge clk);
    @(negedge clk);
    check("cmp_flags", 32'(flags), 32'hC);
    check("cmp_no_wb", 32'(wb_valid), 32'd0);
    check("cmp_in_ready", 32'(in_ready), 32'd1);

    // ADD with NE after Z=1
`ifndef EXEC_COND_EN
    wb_q.push_back('{rd: 4'd2, data: 32'd12});
`endif
    issue(ADD, NE, 1'b0, 32'd5, 32'd7, 4'd2, 32'd0);
    @(negedge clk);
    check("ne_exec_in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
`ifdef EXEC_COND_EN
    check("ne_skip_no_wb", 32'(wb_valid), 32'd0);
    check("ne_skip_in_ready", 32'(in_ready), 32'd1);
`else
    check("ne_exec_wb_valid", 32'(wb_valid), 32'd1);
`endif

    // Condition sweep with flags Z=1 C=1 N=0 V=0
    tc = '{EQ, NE, CS, CC, HI, LS, GE, LT, GT, LE, MI, PL, AL};
    tp = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 13; i++) begin
`ifdef EXEC_COND_EN
      exp_pass = tp[i];
`else
      exp_pass = 1'b1;
`endif
      if (exp_pass) wb_q.push_back('{rd: 4'(i), data: 32'h100 + 32'(i)});
      issue(ADD, tc[i], 1'b0, 32'(i), 32'h100, 4'(i), 32'd0);
    end
    wait_ready();
    @(negedge clk);
    check("sweep_flags_kept", 32'(flags), 32'hC);

    // SUB 0-1, S=0: all-ones result, flags untouched
    wb_q.push_back('{rd: 4'd6, data: 32'hFFFF_FFFF});
    issue(SUB, AL, 1'b0, 32'd0, 32'd1, 4'd6, 32'd0);
    @(negedge clk); @(negedge clk); @(negedge clk);
    check("sub_flags_kept", 32'(flags), 32'hC);

    // LDR 0x100+4, ack on the third request cycle; S=1 must not touch flags
    mem_q.push_back('{we: 1'b0, addr: 32'h104, wdata: 32'd0});
    wb_q.push_back('{rd: 4'd7, data: 32'h0000_CAFE});
    issue(LDR, AL, 1'b1, 32'h100, 32'd4, 4'd7, 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check("ldr_mem_req", 32'(mem_req), 32'd1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    mem_ack = 1'b1; mem_rdata = 32'h0000_CAFE;
    @(posedge clk); #1;
    mem_ack = 1'b0; mem_rdata = '0;
    @(negedge clk); @(negedge clk);
    check("ldr_flags_kept", 32'(flags), 32'hC);
    check("ldr_mem_req_drop", 32'(mem_req), 32'd0);

    // STR with no ack: 4 request cycles, one mem_err pulse, no writeback
    err0 = err_seen;
    req_cnt = 0;
    issue(STR, AL, 1'b0, 32'h200, 32'h10, 4'd8, 32'hDEAD_BEEF);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (mem_req) begin
        req_cnt++;
        if (req_cnt == 1) begin
          check("str_mem_addr", mem_addr, 32'h210);
          check("str_mem_we", 32'(mem_we), 32'd1);
          check("str_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
        end
      end
    end
    check("tmo_req_cycles", 32'(req_cnt), 32'd4);
    check("tmo_err_pulses", 32'(err_seen - err0), 32'd1);
    check("tmo_in_ready", 32'(in_ready), 32'd1);
    check("tmo_no_wb", 32'(wb_valid), 32'd0);

    // STR acked in the same cycle the timeout expires: ack wins
    err0 = err_seen;
    mem_q.push_back('{we: 1'b1, addr: 32'h304, wdata: 32'h1234_5678});
    issue(STR, AL, 1'b0, 32'h300, 32'd4, 4'd8, 32'h1234_5678);
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    mem_ack = 1'b1;
    @(posedge clk); #1;
    mem_ack = 1'b0;
    @(negedge clk); @(negedge clk);
    check("ack_wins_no_err", 32'(err_seen - err0), 32'd0);
    check("ack_wins_idle", 32'(in_ready), 32'd1);
    check("ack_wins_req_drop", 32'(mem_req), 32'd0);

    // Writeback stalled, then reset mid-op: data stable, reset clears everything
    wb_ready = 1'b0;
    issue(ADD, AL, 1'b0, 32'h10, 32'h20, 4'd9, 32'd0);
    @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("stall_wb_valid", 32'(wb_valid), 32'd1);
      check("stall_wb_data", wb_data, 32'h30);
      check("stall_wb_rd", 32'(wb_rd), 32'd9);
    end
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_wb_valid", 32'(wb_valid), 32'd0);
    check("rst_mid_flags", 32'(flags), 32'd0);
    check("rst_mid_in_ready", 32'(in_ready), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", 32'(in_ready), 32'd1);
    check("post_rst_flags", 32'(flags), 32'd0);
    wb_ready = 1'b1;
    @(negedge clk);

    check("wb_queue_drained", 32'(wb_q.size()), 32'd0);
    check("mem_queue_drained", 32'(mem_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
